// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma symbol, lane count and RX alignment states.
package phy_pkg;

  localparam logic [7:0]  COM   = 8'hBC;
  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StActive = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_lane_demux.sv
// Distributes recovered data bytes round-robin onto per-lane holding registers.
module phy_rx_lane_demux
  import phy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [1:0] lane_i,
  input  logic [7:0] byte_i,
  output logic [7:0] out0_o,
  output logic [7:0] out1_o,
  output logic [7:0] out2_o,
  output logic [7:0] out3_o,
  output logic [3:0] validmux41_o
);

  logic [7:0]       lane_q [LANES];
  logic [LANES-1:0] onehot;
  logic [LANES-1:0] validmux_q;

  always_comb begin
    onehot = '0;
    if (valid_i) onehot[lane_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      validmux_q <= '0;
    end else begin
      validmux_q <= onehot;
      if (valid_i) lane_q[lane_i] <= byte_i;
    end
  end

  assign out0_o       = lane_q[0];
  assign out1_o       = lane_q[1];
  assign out2_o       = lane_q[2];
  assign out3_o       = lane_q[3];
  assign validmux41_o = validmux_q;

endmodule

// File: rtl/phy_rx_deserializer.sv
// Serial-to-parallel receiver: COM-based byte alignment, idle stripping and
// round-robin lane distribution of data bytes.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic       active,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic [1:0] out_lane,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] validmux41
);

  localparam logic [3:0] LockCnt = 4'(BC_LOCK);

  rx_state_e  state_q, state_d;
  logic [7:0] sr_q, nxt;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [1:0] lane_ptr_q, lane_ptr_d;
  logic       active_q, out_valid_q;
  logic [7:0] out_byte_q;
  logic [1:0] out_lane_q;
  logic       is_com, boundary, data_hit;

  always_comb begin
    nxt        = {sr_q[6:0], in_serial};
    is_com     = (nxt == COM);
    boundary   = (bit_cnt_q == 3'd7);
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    com_cnt_d  = com_cnt_q;
    lane_ptr_d = lane_ptr_q;
    data_hit   = 1'b0;
    unique case (state_q)
      StSearch: begin
        // Bit-sliding hunt: every edge is a candidate byte boundary.
        bit_cnt_d = '0;
        if (is_com) begin
          com_cnt_d = 4'd1;
          state_d   = (BC_LOCK == 1) ? StActive : StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_d == LockCnt) state_d = StActive;
          end else begin
            com_cnt_d = '0;
            state_d   = StSearch;
          end
        end
      end
      StActive: begin
        if (boundary && !is_com) begin
          data_hit   = 1'b1;
          lane_ptr_d = lane_ptr_q + 2'd1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk32f) begin
    if (reset) begin
      state_q     <= StSearch;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      com_cnt_q   <= '0;
      lane_ptr_q  <= '0;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= nxt;
      bit_cnt_q   <= bit_cnt_d;
      com_cnt_q   <= com_cnt_d;
      lane_ptr_q  <= lane_ptr_d;
      active_q    <= active_q | (state_d == StActive);
      out_valid_q <= data_hit;
      if (data_hit) begin
        out_byte_q <= nxt;
        out_lane_q <= lane_ptr_q;
      end
    end
  end

  phy_rx_lane_demux u_demux (
    .clk_i        (clk32f),
    .rst_i        (reset),
    .valid_i      (data_hit),
    .lane_i       (lane_ptr_q),
    .byte_i       (nxt),
    .out0_o       (out0),
    .out1_o       (out1),
    .out2_o       (out2),
    .out3_o       (out3),
    .validmux41_o (validmux41)
  );

  assign active    = active_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_lane  = out_lane_q;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Scoreboard bench: a stream-level model predicts lock point and data pulses.
module tb_phy_rx_deserializer;
  import phy_pkg::*;

  logic       clk32f = 1'b0;
  logic       reset = 1'b1;
  logic       in_serial = 1'b0;

  logic       act, ov, act1, ov1;
  logic [7:0] ob, o0, o1, o2, o3, ob1, p0, p1, p2, p3;
  logic [1:0] ol, ol1;
  logic [3:0] vm, vm1;

  phy_rx_deserializer #(.BC_LOCK(4)) dut (
    .clk32f(clk32f), .reset(reset), .in_serial(in_serial), .active(act),
    .out_byte(ob), .out_valid(ov), .out_lane(ol), .out0(o0), .out1(o1),
    .out2(o2), .out3(o3), .validmux41(vm)
  );

  phy_rx_deserializer #(.BC_LOCK(1)) dut1 (
    .clk32f(clk32f), .reset(reset), .in_serial(in_serial), .active(act1),
    .out_byte(ob1), .out_valid(ov1), .out_lane(ol1), .out0(p0), .out1(p1),
    .out2(p2), .out3(p3), .validmux41(vm1)
  );

  always #5 clk32f = ~clk32f;

  typedef struct {
    int         at_edge;
    logic [7:0] data;
    int         lane;
  } exp_t;

  exp_t       sb[$];
  bit         stream[$];
  int         lock4 = -1, lock1 = -1;
  int         n_checks = 0, n_fail = 0;
  int         edge_idx = 0;
  logic       rst_q = 1'b1;
  bit         running = 1'b0;
  logic [7:0] exp_hold [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_idx - 1);
    end
  endtask

  // 8-bit window ending at bit j, MSB first, zero-padded before the stream.
  function automatic logic [7:0] win(input int j);
    logic [7:0] w = '0;
    for (int k = 0; k < 8; k++) begin
      int idx = j - 7 + k;
      w = {w[6:0], (idx >= 0) ? stream[idx] : 1'b0};
    end
    return w;
  endfunction

  // Edge index at which `need` consecutive aligned COMs complete, or -1.
  function automatic int find_lock(input int n, input int need);
    int i, j, k, cnt;
    i = 0;
    while (i < n) begin
      j = i;
      while (j < n && win(j) != COM) j++;
      if (j >= n) return -1;
      k   = j;
      cnt = 1;
      while (cnt < need && k + 8 < n && win(k + 8) == COM) begin
        k += 8;
        cnt++;
      end
      if (cnt == need) return k;
      if (k + 8 >= n) return -1;
      i = k + 9;
    end
    return -1;
  endfunction

  task automatic load_model(input int n);
    int   lane;
    exp_t it;
    lock4 = find_lock(n, 4);
    lock1 = find_lock(n, 1);
    sb.delete();
    lane = 0;
    if (lock4 >= 0) begin
      for (int e = lock4 + 8; e < n; e += 8) begin
        if (win(e) != COM) begin
          it.at_edge = e;
          it.data    = win(e);
          it.lane    = lane;
          sb.push_back(it);
          lane = (lane + 1) % 4;
        end
      end
    end
  endtask

  always @(posedge clk32f) begin
    rst_q    <= reset;
    edge_idx <= reset ? 0 : edge_idx + 1;
  end

  always @(negedge clk32f) begin
    int   last;
    exp_t it;
    if (rst_q) begin
      chk("reset_outputs", {act, ob, ov, ol, o0, o1, o2, o3, vm}, '0);
      chk("reset_active_lock1", act1, 0);
      for (int i = 0; i < 4; i++) exp_hold[i] = '0;
    end else if (running) begin
      last = edge_idx - 1;
      chk("active", act, (lock4 >= 0 && last >= lock4) ? 1 : 0);
      chk("active_lock1", act1, (lock1 >= 0 && last >= lock1) ? 1 : 0);
      if (ov) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", {ob, ol}, 0);
        end else begin
          it = sb.pop_front();
          chk("pulse_edge", last, it.at_edge);
          chk("out_byte", ob, it.data);
          chk("out_lane", ol, it.lane);
          chk("validmux41", vm, 1 << it.lane);
          exp_hold[it.lane] = it.data;
          chk("lanes", {o0, o1, o2, o3},
              {exp_hold[0], exp_hold[1], exp_hold[2], exp_hold[3]});
        end
      end else begin
        chk("validmux_idle", vm, 0);
        if (sb.size() > 0 && sb[0].at_edge <= last) begin
          it = sb.pop_front();
          chk("missed_pulse", ob, {24'h0, it.data} | 32'h100);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
  endtask

  task automatic run_scn(input int cut);
    running   = 1'b0;
    reset     = 1'b1;
    in_serial = 1'b0;
    repeat (2) @(posedge clk32f);
    load_model(cut);
    #1;
    reset   = 1'b0;
    running = 1'b1;
    for (int i = 0; i < cut; i++) begin
      in_serial = stream[i];
      @(posedge clk32f);
      #1;
    end
    @(negedge clk32f);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] b;
    // Clean lock
    stream.delete();
    repeat (6) push_byte(COM);
    run_scn(stream.size());
    // Misaligned start
    stream.delete();
    stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    repeat (6) push_byte(COM);
    run_scn(stream.size());
    // Broken lock
    stream.delete();
    push_byte(COM); push_byte(COM); push_byte(8'h55);
    repeat (6) push_byte(COM);
    run_scn(stream.size());
    // Data distribution including an idle slot
    stream.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h11); push_byte(8'h22); push_byte(COM);
    push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    repeat (2) push_byte(COM);
    run_scn(stream.size());
    // Reset lands on the edge that would complete the third data byte
    stream.delete();
    repeat (4) push_byte(COM);
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3); push_byte(8'hD4);
    run_scn(32 + 16 + 7);
    // Relock after reset: first byte on lane 0
    stream.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h5A); push_byte(8'h6B); push_byte(COM);
    run_scn(stream.size());
    // Randomized: junk prefix, lock, mixed data and idles
    for (int r = 0; r < 10; r++) begin
      stream.delete();
      repeat ($urandom_range(0, 15)) stream.push_back(1'($urandom));
      repeat (4) push_byte(COM);
      for (int d = 0; d < 16; d++) begin
        b = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
        push_byte(b);
      end
      repeat (2) push_byte(COM);
      run_scn(stream.size());
    end
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
